// File: rtl/fsm_job_sched_pkg.sv
// Shared definitions for the job scheduler: FSM state codes, controller states
// and the round-robin pick used by the arbiter.
package fsm_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN0 = 2'd1;
  localparam logic [1:0] ST_RUN1 = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_DRAIN,
    S_REL
  } ctrl_state_t;

  // Returns {found, index}: first set bit of req at or above ptr, wrapping at nreq (<= 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input logic [3:0] nreq);
    logic       found;
    logic [2:0] idx;
    logic [3:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= nreq) cand = cand - nreq;
      if ((4'(i) < nreq) && !found && req[cand[2:0]]) begin
        found = 1'b1;
        idx   = cand[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
module rr_arbiter
  import fsm_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [3:0] pick;

  assign pick     = rr_pick(8'(req_i), 3'(ptr_i), 4'(NREQ));
  assign any_o    = pick[3];
  assign idx_o    = IDX_W'(pick[2:0]);
  assign onehot_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/fsm_job_sched.sv
// Round-robin job scheduler owning the start/stop/mode inputs of one shared run/stop FSM.
// Each granted requester gets one start-run-stop-drain job, then a one-cycle done pulse.
module fsm_job_sched
  import fsm_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  start,
  output logic                  stop,
  output logic                  mode,
  input  logic [1:0]            fsm_state
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  ctrl_state_t       state_q;
  logic [IDX_W-1:0]  ptr_q, idx_q, ptr_d;
  logic              job_mode_q;
  logic [LEN_W-1:0]  len_q, cnt_q, len_d, pick_len;
  logic [WAIT_W-1:0] wait_q;
  logic [NREQ-1:0]   grant_q, done_q;
  logic              busy_q, err_q, err_d, start_q, stop_q, mode_q;

  logic [NREQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic              run_ack, stop_ack, mode_bad, to_hit, err_set, go_rel;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (arb_onehot),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  assign pick_len = req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign len_d    = (pick_len == '0) ? LEN_W'(1) : pick_len;
  assign ptr_d    = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + IDX_W'(1);
  assign run_ack  = (fsm_state == ST_RUN0) || (fsm_state == ST_RUN1);
  assign stop_ack = (fsm_state == ST_STOP) || (fsm_state == ST_IDLE);
  assign mode_bad = (fsm_state == ST_RUN1) != job_mode_q;
  assign to_hit   = (wait_q == WAIT_W'(TIMEOUT - 1));

  // A wrong-mode acknowledge still advances the job; only the flag records it.
  always_comb begin
    err_set = 1'b0;
    go_rel  = 1'b0;
    case (state_q)
      S_START: begin
        if (run_ack) err_set = mode_bad;
        else if (to_hit) begin
          err_set = 1'b1;
          go_rel  = 1'b1;
        end
      end
      S_STOP: begin
        if (!stop_ack && to_hit) begin
          err_set = 1'b1;
          go_rel  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fsm_state == ST_IDLE) go_rel = 1'b1;
        else if (to_hit) begin
          err_set = 1'b1;
          go_rel  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign err_d = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      job_mode_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            idx_q      <= arb_idx;
            job_mode_q <= req_mode[arb_idx];
            len_q      <= len_d;
            grant_q    <= arb_onehot;
            busy_q     <= 1'b1;
            start_q    <= 1'b1;
            mode_q     <= req_mode[arb_idx];
            wait_q     <= '0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (run_ack) begin
            cnt_q   <= len_q - LEN_W'(1);
            state_q <= S_RUN;
          end else wait_q <= wait_q + WAIT_W'(1);
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            start_q <= 1'b0;
            stop_q  <= 1'b1;
            wait_q  <= '0;
            state_q <= S_STOP;
          end else cnt_q <= cnt_q - LEN_W'(1);
        end
        S_STOP: begin
          if (stop_ack) begin
            stop_q  <= 1'b0;
            wait_q  <= '0;
            state_q <= S_DRAIN;
          end else wait_q <= wait_q + WAIT_W'(1);
        end
        S_DRAIN: wait_q <= wait_q + WAIT_W'(1);
        S_REL:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // Release cycle: grant and busy drop while done pulses; S_IDLE follows for one cycle.
      if (go_rel) begin
        grant_q <= '0;
        done_q  <= grant_q;
        busy_q  <= 1'b0;
        start_q <= 1'b0;
        stop_q  <= 1'b0;
        mode_q  <= 1'b0;
        ptr_q   <= ptr_d;
        state_q <= S_REL;
      end
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign start = start_q;
  assign stop  = stop_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_fsm_job_sched.sv
// Bench for fsm_job_sched: behavioural run/stop FSM, job monitor and round-robin reference.
module tb_fsm_job_sched;
  import fsm_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       req_mode = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic                  err_clr = 1'b0;
  logic [NREQ-1:0]       grant, done;
  logic                  busy, err, start, stop, mode;
  logic [1:0]            fsm_state;

  always #5 clk = ~clk;

  fsm_job_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_mode  (req_mode),
    .req_len   (req_len),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .fsm_state (fsm_state)
  );

  // External FSM: moves to the commanded state after lat extra cycles (lat=0 answers in-cycle).
  int         lat = 0;
  bit         stuck = 1'b0;
  bit         wrong_mode = 1'b0;
  logic [1:0] m_q, m_t;
  int         m_cnt;

  always_comb begin
    m_t = m_q;
    case (m_q)
      ST_IDLE: if (start && !stuck) m_t = (mode ^ wrong_mode) ? ST_RUN1 : ST_RUN0;
      ST_RUN0, ST_RUN1: if (stop) m_t = ST_STOP;
      default: if (!stop) m_t = ST_IDLE;
    endcase
    fsm_state = ((m_t != m_q) && (m_cnt >= lat)) ? m_t : m_q;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= ST_IDLE;
      m_cnt <= 0;
    end else begin
      m_q   <= fsm_state;
      m_cnt <= ((m_t != m_q) && (fsm_state == m_q)) ? m_cnt + 1 : 0;
    end
  end

  typedef struct {
    int   idx;
    int   done_idx;
    int   first;
    int   done_cyc;
    int   start_n;
    int   stop_n;
    int   grant_n;
    logic err_d;
    logic mode_s;
  } job_t;

  job_t jobs[$];
  job_t cur;
  bit   in_job = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_ptr = 0;
  int   lens[NREQ];

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_next(input int p, input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // Job monitor with per-cycle output invariants.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) in_job = 1'b0;
    else begin
      checks++;
      if (start && stop) begin
        errors++;
        $display("FAIL start_stop_overlap got start=%0b stop=%0b want not both", start, stop);
      end
      checks++;
      if (busy !== (grant != '0)) begin
        errors++;
        $display("FAIL busy_vs_grant got busy=%0b grant=%b", busy, grant);
      end
      if (grant != '0) begin
        checks++;
        if (!$onehot(grant)) begin
          errors++;
          $display("FAIL grant_onehot got %b want one-hot", grant);
        end
        if (!in_job) begin
          in_job       = 1'b1;
          cur.idx      = oh2idx(grant);
          cur.first    = cyc;
          cur.start_n  = 0;
          cur.stop_n   = 0;
          cur.grant_n  = 0;
          cur.mode_s   = mode;
        end
        cur.grant_n++;
        if (start) cur.start_n++;
        if (stop) cur.stop_n++;
      end else begin
        checks++;
        if ({start, stop, mode} !== 3'b000) begin
          errors++;
          $display("FAIL idle_outputs got start/stop/mode=%b want 000", {start, stop, mode});
        end
      end
      if (done != '0) begin
        checks++;
        if (!$onehot(done) || !in_job) begin
          errors++;
          $display("FAIL done_pulse got done=%b in_job=%0b want one-hot inside job", done, in_job);
        end
        cur.done_idx = oh2idx(done);
        cur.done_cyc = cyc;
        cur.err_d    = err;
        jobs.push_back(cur);
        in_job = 1'b0;
      end
    end
  end

  task automatic wait_job(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      #1;
      ok = (jobs.size() != 0);
    end
  endtask

  task automatic set_len(input int i, input int v);
    lens[i] = v;
    req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_mode = '0; req_len = '0; err_clr = 1'b0;
    lat = 0; stuck = 1'b0; wrong_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) lens[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    jobs.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({grant, done} !== '0) begin
      errors++;
      $display("FAIL reset_grant_done got grant=%b done=%b want 0", grant, done);
    end
    checks++;
    if ({busy, err, start, stop, mode} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy/err/start/stop/mode=%b want 0", {busy, err, start, stop, mode});
    end
    do_reset();
  endtask

  task automatic test_single();
    bit   ok;
    job_t j;
    int   t0;
    lat = 0;
    set_len(0, 3);
    req_mode = '0;
    req = 4'b0001;
    t0 = cyc;
    wait_job(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wait got no done want done"); return; end
    j = jobs.pop_front();
    req = '0;
    checks++;
    if (j.idx != 0 || j.done_idx != 0) begin
      errors++;
      $display("FAIL single_idx got grant %0d done %0d want 0", j.idx, j.done_idx);
    end
    checks++;
    if (j.first != t0 + 1) begin
      errors++;
      $display("FAIL single_latency got %0d want %0d", j.first - t0, 1);
    end
    checks++;
    if (j.start_n != 4 || j.stop_n != 1) begin
      errors++;
      $display("FAIL single_start_stop got start %0d stop %0d want 4 1", j.start_n, j.stop_n);
    end
    checks++;
    if (j.grant_n != 6 || j.err_d !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got grant cycles %0d err %0b want 6 0", j.grant_n, j.err_d);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL single_after got busy %0b grant %b want 0", busy, grant);
    end
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    bit   ok;
    job_t j;
    int   exp, prev_done;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    prev_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_job(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_wait got no done want done"); return; end
      j = jobs.pop_front();
      if (k == 4) req = '0;
      exp = rr_next(m_ptr, 4'b1111);
      checks++;
      if (j.idx != exp || j.done_idx != exp) begin
        errors++;
        $display("FAIL rr_order job %0d got %0d want %0d", k, j.idx, exp);
      end
      if (k > 0) begin
        checks++;
        if (j.first - prev_done != 2) begin
          errors++;
          $display("FAIL rr_gap job %0d got %0d want 2", k, j.first - prev_done);
        end
      end
      checks++;
      if (j.start_n != 2) begin
        errors++;
        $display("FAIL rr_start job %0d got %0d want 2", k, j.start_n);
      end
      prev_done = j.done_cyc;
      m_ptr = (exp + 1) % NREQ;
    end
  endtask

  task automatic test_len_zero();
    bit   ok;
    job_t j;
    lat = 1;
    for (int lv = 0; lv < 2; lv++) begin
      set_len(0, lv);
      req = 4'b0001;
      wait_job(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL len_wait got no done want done"); return; end
      j = jobs.pop_front();
      req = '0;
      checks++;
      if (j.start_n != lat + 2 || j.grant_n != 3 * (lat + 1) + 1) begin
        errors++;
        $display("FAIL len%0d_run got start %0d grant %0d want %0d %0d",
                 lv, j.start_n, j.grant_n, lat + 2, 3 * (lat + 1) + 1);
      end
    end
    lat = 0;
    m_ptr = 1;
  endtask

  task automatic test_mode_mismatch();
    bit   ok;
    job_t j;
    wrong_mode = 1'b1;
    req_mode = 4'b0100;
    set_len(2, 2);
    req = 4'b0100;
    wait_job(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mm_wait got no done want done"); return; end
    j = jobs.pop_front();
    req = '0;
    wrong_mode = 1'b0;
    checks++;
    if (j.err_d !== 1'b1 || j.done_idx != 2 || j.mode_s !== 1'b1) begin
      errors++;
      $display("FAIL mm_job got err %0b done %0d mode %0b want 1 2 1", j.err_d, j.done_idx, j.mode_s);
    end
    checks++;
    if (j.start_n != 3 || j.stop_n != 1) begin
      errors++;
      $display("FAIL mm_phases got start %0d stop %0d want 3 1", j.start_n, j.stop_n);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL mm_sticky got err %0b want 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    #1;
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL mm_clear got err %0b want 0", err); end
    req_mode = '0;
    m_ptr = 3;
  endtask

  task automatic test_timeout();
    bit   ok;
    job_t j;
    stuck = 1'b1;
    set_len(3, 5);
    req = 4'b1000;
    wait_job(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_wait got no done want done"); return; end
    j = jobs.pop_front();
    req = '0;
    checks++;
    if (j.err_d !== 1'b1 || j.done_idx != 3) begin
      errors++;
      $display("FAIL to_err got err %0b done %0d want 1 3", j.err_d, j.done_idx);
    end
    checks++;
    if (j.start_n != TIMEOUT || j.stop_n != 0 || j.grant_n != TIMEOUT) begin
      errors++;
      $display("FAIL to_phases got start %0d stop %0d grant %0d want %0d 0 %0d",
               j.start_n, j.stop_n, j.grant_n, TIMEOUT, TIMEOUT);
    end
    checks++;
    if (start !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL to_release got start %0b grant %b want 0", start, grant);
    end
    stuck = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    #1;
    err_clr = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset_mid_job();
    bit   ok;
    job_t j;
    set_len(3, 10);
    req = 4'b1000;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      #1;
      ok = (grant != '0);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_grant_wait got no grant want grant"); return; end
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start, stop, mode, busy} !== 4'b0 || {grant, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got s/s/m/b=%b grant=%b done=%b want 0",
               {start, stop, mode, busy}, grant, done);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (jobs.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_done got %0d done pulses want 0", jobs.size());
    end
    rst_n = 1'b1;
    m_ptr = 0;
    set_len(1, 2);
    req = 4'b1010;
    wait_job(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_after_wait got no done want done"); return; end
    j = jobs.pop_front();
    req = '0;
    checks++;
    if (j.idx != 1) begin
      errors++;
      $display("FAIL rst_after_idx got %0d want 1", j.idx);
    end
    m_ptr = 2;
  endtask

  task automatic test_random();
    bit   ok;
    job_t j;
    int   exp, len_e;
    for (int b = 0; b < 12; b++) begin
      req_mode = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_len(i, int'($urandom_range(0, 5)));
      lat = int'($urandom_range(0, 2));
      wrong_mode = ($urandom_range(0, 3) == 0);
      req = NREQ'($urandom_range(1, 15));
      for (int k = 0; k < 3; k++) begin
        wait_job(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rnd_wait burst %0d got no done want done", b); return; end
        j = jobs.pop_front();
        exp = rr_next(m_ptr, req);
        len_e = (lens[exp] == 0) ? 1 : lens[exp];
        checks++;
        if (j.idx != exp || j.done_idx != exp) begin
          errors++;
          $display("FAIL rnd_idx burst %0d got %0d/%0d want %0d", b, j.idx, j.done_idx, exp);
        end
        checks++;
        if (j.start_n != lat + 1 + len_e || j.stop_n != lat + 1 ||
            j.grant_n != 3 * (lat + 1) + len_e) begin
          errors++;
          $display("FAIL rnd_phases burst %0d got %0d/%0d/%0d want %0d/%0d/%0d", b,
                   j.start_n, j.stop_n, j.grant_n, lat + 1 + len_e, lat + 1, 3 * (lat + 1) + len_e);
        end
        checks++;
        if (j.mode_s !== req_mode[exp] || j.err_d !== logic'(wrong_mode)) begin
          errors++;
          $display("FAIL rnd_mode_err burst %0d got mode %0b err %0b want %0b %0b",
                   b, j.mode_s, j.err_d, req_mode[exp], wrong_mode);
        end
        m_ptr = (exp + 1) % NREQ;
        err_clr = 1'b1;
        @(negedge clk);
        #1;
        err_clr = 1'b0;
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_len_zero();
    test_mode_mismatch();
    test_timeout();
    test_reset_mid_job();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_job_sched.md
Name: fsm_job_sched

Overview:
Round-robin scheduler that shares one run/stop control FSM (ports start, stop, mode, state[1:0]) among NREQ requesters. Each granted requester gets one job: start the FSM in its requested mode, hold it running for a requested cycle count, stop it, confirm it returned to idle, then release it. Sits between client blocks and the shared FSM, and owns that FSM's start/stop/mode inputs exclusively.

Parameters:
NREQ, 4, number of requesters (2..8)
LEN_W, 8, width of per-request run length
TIMEOUT, 16, max cycles to wait for an FSM state acknowledge before flagging error

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester job request, level
req_mode  in  NREQ  per-requester mode bit, sampled at grant
req_len  in  NREQ*LEN_W  per-requester run length, slice i = [i*LEN_W +: LEN_W], sampled at grant
grant  out  NREQ  one-hot grant, held for the whole job
done  out  NREQ  one-cycle pulse to the granted requester at job end
busy  out  1  high while any job is in progress
err  out  1  sticky timeout flag
err_clr  in  1  clears err (synchronous)
start  out  1  to FSM start
stop  out  1  to FSM stop
mode  out  1  to FSM mode
fsm_state  in  2  FSM state feedback

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n=0, all outputs are 0, controller is in S_IDLE, rr pointer is 0 and all counters are 0. Reset mid-job abandons the job with no done pulse.
- FSM state encoding: ST_IDLE=0, ST_RUN0=1 (mode 0), ST_RUN1=2 (mode 1), ST_STOP=3.
- Controller states: S_IDLE, S_START, S_RUN, S_STOP, S_DRAIN, S_REL.
- S_IDLE: when req≠0, pick the first set bit scanning from ptr upward with wrap. Latch its index, mode and length; a length of 0 is treated as 1. Next cycle: grant one-hot, busy=1, state → S_START. Grant latency from req is 1 cycle when idle.
- S_START: start=1, mode=latched mode. Exit to S_RUN on the first cycle fsm_state is ST_RUN0 or ST_RUN1. A run state that does not match the latched mode still counts as an acknowledge, but sets err.
- S_RUN: start stays 1. The run counter loads len−1 on entry and decrements each cycle. When it reaches 0, go to S_STOP. S_RUN lasts exactly max(len,1) cycles.
- S_STOP: start=0, stop=1. Exit to S_DRAIN when fsm_state is ST_STOP or ST_IDLE.
- S_DRAIN: stop=0. Exit to S_REL when fsm_state is ST_IDLE.
- S_REL: done[idx]=1 for one cycle, grant drops, busy=0, ptr=(idx+1) mod NREQ. The next cycle is S_IDLE, so back-to-back grants are separated by exactly 1 idle cycle.
- mode output: driven to the latched mode from S_START through S_DRAIN, 0 otherwise.
- Timeout: the wait counter resets on each entry to S_START, S_STOP or S_DRAIN. If it reaches TIMEOUT, set err and jump to S_REL (done still pulses, FSM outputs return to 0).
- err: stays set until err_clr=1. If err_clr and a new error occur in the same cycle, set wins.
- req sampling: req, req_mode and req_len changes after grant are ignored. Dropping req mid-job does not abort the job. A requester still asserting req at S_IDLE is eligible again, but only in round-robin order.
- Simultaneous requests: strict round robin from ptr, with no starvation. Worst-case wait is NREQ−1 jobs.
- start and stop are never high in the same cycle.

Decomposition:
- Package fsm_sched_pkg:
  - FSM state encoding (ST_IDLE..ST_STOP)
  - controller state enum (S_IDLE..S_REL)
  - function for the round-robin index pick
- Sub-module rr_arbiter (req, ptr → one-hot and index, combinational). It is natural to reuse it elsewhere.

Test Plan:
1. Single request, len=3: req=0001, mode=0, len=3, with an FSM model that acknowledges in 1 cycle. Expect grant=0001 one cycle later, start high exactly 1+3 cycles, stop for 1 cycle, done[0] pulse, busy low after.
2. Round robin with all requesting: req=1111 continuously, len=1. Expect grants in order 0001, 0010, 0100, 1000, 0001, with one idle cycle between jobs.
3. Length zero: len=0. Expect the S_RUN phase to last 1 cycle, identical to len=1.
4. Mode mismatch: req_mode=1, FSM model answers ST_RUN0. Expect err=1, job completes normally, done pulses; err_clr clears err the next cycle.
5. Timeout: FSM model stuck in ST_IDLE after start. Expect err=1 after 16 wait cycles, done pulse, start=0, grant released.
6. Reset mid-job: assert rst_n=0 during S_RUN, len=10. Expect start, stop, mode, grant, busy and done all 0 immediately with no done pulse; after release, the first grant goes to the lowest requesting index.
